// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC->MAR, RAM read, IR load, ARM condition check, execute handshake.
// Optional MEM_RD timeout with sticky FAULT when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        RUN,
  input  logic        MFC,
  input  logic [3:0]  Flags,
  input  logic [31:0] IR_Out,
  input  logic        EXEC_DONE,
  output logic        MFA,
  output logic        RW_RAM,
  output logic        MAR_EN,
  output logic        IR_EN,
  output logic        RF_RW,
  output logic        SALU,
  output logic        EXEC_REQ,
  output logic [2:0]  State,
  output logic        FAULT
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMarLd = 3'd1,
    StMemRd = 3'd2,
    StIrLd  = 3'd3,
    StCond  = 3'd4,
    StExec  = 3'd5,
    StFault = 3'd6
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $fatal(1, "TIMEOUT_CYCLES must be at least 1");
  end

  state_e state_q, state_d;
  logic   cond_ok;

  // Flags are {N,Z,C,V}; code 15 (NV) never executes.
  function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_pass(IR_Out[31:28], Flags);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            timeout;

  // cnt_q holds the number of edges already spent in MEM_RD without MFC.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (RUN) state_d = StMarLd;
      StMarLd: state_d = StMemRd;
      StMemRd: begin
        if (MFC) begin
          state_d = StIrLd;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StFault;
`endif
        end
      end
      StIrLd:  state_d = StCond;
      StCond:  state_d = cond_ok ? StExec : (RUN ? StMarLd : StIdle);
      StExec:  if (EXEC_DONE) state_d = RUN ? StMarLd : StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they always match State.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= StIdle;
      MFA      <= 1'b1;
      RW_RAM   <= 1'b1;
      MAR_EN   <= 1'b0;
      IR_EN    <= 1'b0;
      RF_RW    <= 1'b0;
      SALU     <= 1'b0;
      EXEC_REQ <= 1'b0;
    end else begin
      state_q  <= state_d;
      MFA      <= !((state_d == StMemRd) || (state_d == StIrLd));
      RW_RAM   <= 1'b1;
      MAR_EN   <= (state_d == StMarLd);
      IR_EN    <= (state_d == StIrLd);
      RF_RW    <= (state_d == StMarLd);
      SALU     <= (state_d == StMarLd);
      EXEC_REQ <= (state_d == StExec);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt_q <= '0;
      FAULT <= 1'b0;
    end else begin
      cnt_q <= (state_q == StMemRd) ? cnt_q + 1'b1 : '0;
      FAULT <= (state_d == StFault);
    end
  end
`else
  assign FAULT = 1'b0;
`endif

  assign State = state_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: MFC wait limit in cycles, used only when FETCH_TIMEOUT_EN is defined.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-high.
REQ-004 RUN  input  1  enables instruction fetch while high.
REQ-005 MFC  input  1  memory function complete, from the RAM.
REQ-006 Flags  input  4  condition flags {N,Z,C,V} = Flags[3:0].
REQ-007 IR_Out  input  32  instruction register contents from the datapath.
REQ-008 EXEC_DONE  input  1  execute unit finished the current instruction.
REQ-009 MFA  output  1  memory function active (active-low, matching the datapath).
REQ-010 RW_RAM  output  1  RAM direction; 1 = read.
REQ-011 MAR_EN, IR_EN, RF_RW  outputs  1 each  load enables for MAR, IR and PC write-back.
REQ-012 SALU  output  1  selects ALU PC+4 onto the register-file write bus.
REQ-013 EXEC_REQ  output  1  execute request to the execute unit.
REQ-014 State  output  3  current FSM state code.
REQ-015 FAULT  output  1  fetch aborted; sticky until CLR.

Function
REQ-016 States and codes: IDLE=0, MAR_LD=1, MEM_RD=2, IR_LD=3, COND=4, EXEC=5, FAULT_ST=6; code 7 unused and shall go to IDLE on the next edge.
REQ-017 IDLE: go to MAR_LD when RUN=1; otherwise stay in IDLE.
REQ-018 MAR_LD, exactly one cycle: MAR_EN=1, RF_RW=1, SALU=1 (MAR<-PC and PC<-PC+4 on the same edge); then go to MEM_RD.
REQ-019 MEM_RD: MFA=0, RW_RAM=1; hold until a rising edge samples MFC=1, then go to IR_LD.
REQ-020 IR_LD, exactly one cycle: IR_EN=1 with MFA=0 and RW_RAM=1 still driven; then go to COND.
REQ-021 COND, one cycle: evaluate ARM condition IR_Out[31:28] against Flags.
- Codes 0-14 use standard ARM semantics (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL).
- Code 15 always fails.
- Pass: go to EXEC. Fail: go to MAR_LD if RUN=1, else IDLE.
REQ-022 EXEC: EXEC_REQ=1, held until EXEC_DONE=1 is sampled. On that edge go to MAR_LD if RUN=1, else IDLE.
REQ-023 EXEC_DONE outside EXEC shall be ignored.
REQ-024 MFC outside MEM_RD shall be ignored.
REQ-025 RUN falling mid-fetch shall not abort the fetch; RUN is sampled only in IDLE, COND (fail path) and at EXEC exit.
REQ-026 All outputs shall be registered-state decodes (Moore outputs), with no combinational path from any input to any output.
REQ-027 Inactive values: MFA=1, RW_RAM=1, every enable 0, EXEC_REQ=0.
REQ-028 Minimum fetch latency, RUN high to EXEC_REQ with MFC returned in the first MEM_RD cycle: 5 edges (IDLE->MAR_LD->MEM_RD->IR_LD->COND->EXEC).

Reset
REQ-029 CLR high shall immediately force State=IDLE, FAULT=0 and all outputs to their inactive values, regardless of the clock.
REQ-030 CLR asserted mid-fetch or mid-execute shall abandon the operation; the first transition after CLR deasserts is from IDLE.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN.
- Defined: a counter clears on entry to MEM_RD and increments each cycle spent there. If it reaches TIMEOUT_CYCLES without MFC, go to FAULT_ST. FAULT_ST sets FAULT=1, keeps outputs inactive, and is exited only by CLR.
- Undefined: no counter is built, MEM_RD waits indefinitely, FAULT is tied to 0, and FAULT_ST is unreachable.

Verification
REQ-032 CLR pulse while in MEM_RD -> State=0, MFA=1 and all enables 0 in the same cycle, without waiting for a clock edge.
REQ-033 RUN=1, MFC returned 3 cycles after MEM_RD entry, IR_Out=32'hE0000000 (AL) -> MAR_EN pulses once, IR_EN pulses once, EXEC_REQ=1 on edge 7.
REQ-034 IR_Out=32'h00000000 (EQ), Flags=4'b0000 -> COND fails, EXEC_REQ stays 0, next state MAR_LD.
REQ-035 IR_Out=32'hB0000000 (LT), Flags=4'b1000 (N=1, V=0) -> condition passes, EXEC_REQ=1; with Flags=4'b1001 -> condition fails.
REQ-036 RUN dropped while in EXEC, then EXEC_DONE=1 -> State=0 on the next edge and no further MAR_EN.
REQ-037 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, MFC held at 0 -> FAULT=1 and State=6 after 16 cycles in MEM_RD; a later MFC=1 has no effect until CLR.
